// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RISC-V fields and an immediate into a 32-bit
// instruction word, buffers up to two words and streams them to the
// instruction-memory write port at an auto-incrementing byte address.
module inst_encoder #(
    parameter int INST_W = 32,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [6:0]        i_opcode,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [DATA_W-1:0] i_imm,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [INST_W-1:0] o_wr_data,
    output logic              o_err,
    output logic [7:0]        o_err_cnt
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

    logic [INST_W-1:0] mem0_q, mem0_d;
    logic [INST_W-1:0] mem1_q, mem1_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [INST_W-1:0] enc_word_s;
    logic              enc_legal_s;
    logic              imm_u12_s;
    logic              imm_s12_s;
    logic              full_s;
    logic              accept_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;

    // I/S immediates are unsigned 12-bit; B offsets are signed 12-bit halfwords
    assign imm_u12_s = ~|i_imm[DATA_W-1:12];
    assign imm_s12_s = (&i_imm[DATA_W-1:11]) | (~|i_imm[DATA_W-1:11]);

    assign full_s     = (count_q == 2'd2);
    assign o_ready    = ~full_s & ~i_clr & ~i_rst;
    assign accept_s   = i_valid & o_ready;
    assign push_s     = accept_s & enc_legal_s;
    assign drop_s     = accept_s & ~enc_legal_s;
    assign pop_s      = (count_q != 2'd0) & i_wr_ready & ~i_clr;

    assign o_wr_valid = (count_q != 2'd0);
    assign o_wr_addr  = addr_q;
    assign o_wr_data  = rd_ptr_q ? mem1_q : mem0_q;
    assign o_err      = err_q;
    assign o_err_cnt  = err_cnt_q;

    // Scatter the immediate into the format selected by the opcode and range-check it
    always_comb begin
        enc_word_s  = {INST_W{1'b0}};
        enc_legal_s = 1'b0;
        case (i_opcode)
            OP_IMM, OP_LOAD: begin
                enc_word_s  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_legal_s = imm_u12_s;
            end
            OP_STORE: begin
                enc_word_s  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_legal_s = imm_u12_s;
            end
            OP_BRANCH: begin
                enc_word_s  = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3,
                               i_imm[3:0], i_imm[10], i_opcode};
                enc_legal_s = imm_s12_s;
            end
            OP_REG: begin
                enc_word_s  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                enc_legal_s = 1'b1;
            end
            default: begin
                enc_word_s  = {INST_W{1'b0}};
                enc_legal_s = 1'b0;
            end
        endcase
    end

    // Next state for FIFO, write address and error tracking; clear wins over handshakes
    always_comb begin
        mem0_d    = mem0_q;
        mem1_d    = mem1_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (i_clr) begin
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            count_d   = 2'd0;
            addr_d    = BASE_ADDR;
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
        end else begin
            if (push_s) begin
                if (wr_ptr_q) begin
                    mem1_d = enc_word_s;
                end else begin
                    mem0_d = enc_word_s;
                end
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
                addr_d   = addr_q + ADDR_STEP;
            end else begin
                rd_ptr_d = rd_ptr_q;
                addr_d   = addr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                err_d     = 1'b1;
                err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);
            end else begin
                err_d     = err_q;
                err_cnt_d = err_cnt_q;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem0_q    <= {INST_W{1'b0}};
            mem1_q    <= {INST_W{1'b0}};
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            mem0_q    <= mem0_d;
            mem1_q    <= mem1_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: table-driven vectors, directed multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  f3 = 3'd0;
    logic [6:0]  f7 = 7'd0;
    logic [63:0] imm = 64'd0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;

    inst_encoder #(.INST_W(32), .DATA_W(64), .ADDR_W(4), .BASE_ADDR(4'h0)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(valid), .o_ready(ready),
        .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3),
        .i_funct7(f7), .i_imm(imm), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_err(err), .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference model state
    logic [31:0] mq[$];
    int          m_addr = 0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    bit          last_acc = 0;

    typedef struct { int a; logic [31:0] d; } wr_t;
    wr_t wlog[$];

    typedef struct {
        logic [6:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
        logic [2:0] f3; logic [6:0] f7; logic [63:0] imm; logic legal; logic [31:0] data;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoding derived from the instruction-format field positions using arithmetic
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd_v,
            input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3_v,
            input logic [6:0] f7_v, input logic [63:0] imm_v,
            output logic ok, output logic [31:0] w);
        longint unsigned u, h, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_op, acc;
        longint s;
        u = imm_v; s = imm_v; h = u % 4096;
        a_rd = rd_v; a_rs1 = rs1_v; a_rs2 = rs2_v; a_f3 = f3_v; a_f7 = f7_v; a_op = op;
        acc = 0; ok = 1'b0;
        case (op)
            7'h13, 7'h03: begin
                ok  = (u < 4096);
                acc = (h << 20) + (a_rs1 << 15) + (a_f3 << 12) + (a_rd << 7) + a_op;
            end
            7'h23: begin
                ok  = (u < 4096);
                acc = ((h / 32) << 25) + (a_rs2 << 20) + (a_rs1 << 15) + (a_f3 << 12)
                    + ((h % 32) << 7) + a_op;
            end
            7'h63: begin
                ok  = (s >= -2048) && (s <= 2047);
                acc = (((h >> 11) % 2) << 31) + (((h >> 4) % 64) << 25) + (a_rs2 << 20)
                    + (a_rs1 << 15) + (a_f3 << 12) + ((h % 16) << 8)
                    + (((h >> 10) % 2) << 7) + a_op;
            end
            7'h33: begin
                ok  = 1'b1;
                acc = (a_f7 << 25) + (a_rs2 << 20) + (a_rs1 << 15) + (a_f3 << 12)
                    + (a_rd << 7) + a_op;
            end
            default: ok = 1'b0;
        endcase
        w = acc[31:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr = 0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // one clock cycle: check outputs at negedge, advance model, move to posedge+1
    task automatic step();
        logic [31:0] enc;
        logic        lg;
        bit          acc, pp;
        @(negedge clk);
        chk("ready", ready, (mq.size() < 2) && !clr && !rst);
        chk("wr_valid", wr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, mq[0]);
        end
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        last_acc = valid && ready;
        if (wr_valid && wr_ready && !clr && !rst) wlog.push_back('{int'(wr_addr), wr_data});
        if (rst || clr) begin
            model_reset();
        end else begin
            acc = valid && (mq.size() < 2);
            pp  = (mq.size() != 0) && wr_ready;
            if (pp) begin
                void'(mq.pop_front());
                m_addr = (m_addr + 4) % 16;
            end
            if (acc) begin
                ref_encode(opcode, rd, rs1, rs2, f3, f7, imm, lg, enc);
                if (lg) mq.push_back(enc);
                else begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    // hold a request until it is accepted (bounded)
    task automatic req(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
            input logic [4:0] rs2_v, input logic [2:0] f3_v, input logic [6:0] f7_v,
            input logic [63:0] imm_v);
        bit done = 0;
        opcode = op; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; f3 = f3_v; f7 = f7_v; imm = imm_v;
        valid = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            done = last_acc;
        end
        if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
        valid = 1'b0;
    endtask

    task automatic do_clr();
        valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic chk_wr(input int idx, input int a, input logic [31:0] d);
        if (idx < wlog.size()) begin
            chk("wlog_addr", wlog[idx].a, a);
            chk("wlog_data", wlog[idx].d, d);
        end else begin
            chk("wlog_count", wlog.size(), idx + 1);
        end
    endtask

    logic [3:0]  hold_a;
    logic [31:0] hold_d;

    initial begin
        tbl[0]  = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5,                  1'b1, 32'h00510093};
        tbl[1]  = '{7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 64'd36,                 1'b1, 32'h02312223};
        tbl[2]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 32'hFE208EE3};
        tbl[3]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 64'hDEAD,              1'b1, 32'h002081B3};
        tbl[4]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0,                 1'b1, 32'h402081B3};
        tbl[5]  = '{7'h03, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 64'd8,                  1'b1, 32'h00832283};
        tbl[6]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4095,               1'b1, 32'hFFF00093};
        tbl[7]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd4096,               1'b0, 32'h0};
        tbl[8]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2047,               1'b1, 32'h7E000FE3};
        tbl[9]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_F800, 1'b1, 32'h80000063};
        tbl[10] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048,               1'b0, 32'h0};
        tbl[11] = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd1,                  1'b0, 32'h0};
        tbl[12] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd4096,               1'b0, 32'h0};
        tbl[13] = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'h8000_0000_0000_0005, 1'b0, 32'h0};

        // reset state
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // table vectors, one at a time
        for (int i = 0; i < 14; i++) begin
            wr_ready = 1'b0;
            req(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
            chk("tbl_valid", wr_valid, tbl[i].legal);
            if (tbl[i].legal) chk("tbl_data", wr_data, tbl[i].data);
            wr_ready = 1'b1;
            idle(1);
        end

        // I-type single write, valid one cycle after accept
        do_clr();
        wlog.delete();
        wr_ready = 1'b1;
        req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
        chk("i_valid_next", wr_valid, 1'b1);
        idle(2);
        chk_wr(0, 0, 32'h00510093);

        // S then B back to back
        do_clr();
        wlog.delete();
        req(7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 64'd36);
        req(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(3);
        chk_wr(0, 0, 32'h02312223);
        chk_wr(1, 4, 32'hFE208EE3);
        chk("sb_count", wlog.size(), 2);

        // errors do not write or consume an address
        do_clr();
        wlog.delete();
        req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd4096);
        req(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd2048);
        req(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd0);
        idle(1);
        chk("err_flag", err, 1'b1);
        chk("err_cnt3", err_cnt, 8'd3);
        chk("err_nowrite", wlog.size(), 0);
        req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
        idle(2);
        chk_wr(0, 0, 32'h00510093);

        // backpressure: two buffered, third stalls, outputs hold
        do_clr();
        wlog.delete();
        wr_ready = 1'b0;
        req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1);
        req(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2);
        opcode = 7'h13; rd = 5'd3; rs1 = 5'd0; imm = 64'd3; valid = 1'b1;
        #1;
        chk("bp_ready_low", ready, 1'b0);
        hold_a = wr_addr;
        hold_d = wr_data;
        step(); step(); step();
        chk("bp_hold_addr", wr_addr, hold_a);
        chk("bp_hold_data", wr_data, hold_d);
        chk("bp_hold_valid", wr_valid, 1'b1);
        wr_ready = 1'b1;
        req(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);
        idle(4);
        chk_wr(0, 0, 32'h00100093);
        chk_wr(1, 4, 32'h00200113);
        chk_wr(2, 8, 32'h00300193);

        // address wrap with a 4-bit address, then clear with a word buffered
        do_clr();
        wlog.delete();
        wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'(i));
        idle(3);
        chk_wr(0, 0,  32'h00000093);
        chk_wr(3, 12, 32'h00300093);
        chk_wr(4, 0,  32'h00400093);
        wr_ready = 1'b0;
        req(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd7);
        chk("pre_clr_valid", wr_valid, 1'b1);
        do_clr();
        chk("clr_valid", wr_valid, 1'b0);
        chk("clr_err", err, 1'b0);
        chk("clr_err_cnt", err_cnt, 8'd0);
        wlog.delete();
        wr_ready = 1'b1;
        req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd9);
        idle(2);
        chk_wr(0, 0, 32'h00900093);

        // async reset mid-transfer with the FIFO full
        do_clr();
        wr_ready = 1'b0;
        req(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1);
        req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2);
        wr_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_valid", wr_valid, 1'b0);
        chk("arst_wr_addr", wr_addr, 4'h0);
        chk("arst_wr_data", wr_data, 32'h0);
        chk("arst_err", err, 1'b0);
        chk("arst_err_cnt", err_cnt, 8'd0);
        chk("arst_ready", ready, 1'b0);
        model_reset();
        step();
        rst = 1'b0;
        wlog.delete();
        req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
        idle(2);
        chk_wr(0, 0, 32'h00510093);

        // error counter saturation
        do_clr();
        for (int i = 0; i < 260; i++) req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        idle(1);
        chk("err_cnt_sat", err_cnt, 8'hFF);

        // randomized traffic against the model
        do_clr();
        for (int i = 0; i < 700; i++) begin
            int sel;
            int v;
            valid    = ($urandom_range(0, 9) < 6);
            wr_ready = ($urandom_range(0, 9) < 7);
            clr      = ($urandom_range(0, 59) == 0);
            sel = $urandom_range(0, 6);
            case (sel)
                0: opcode = 7'h13;
                1: opcode = 7'h03;
                2: opcode = 7'h23;
                3: opcode = 7'h63;
                4: opcode = 7'h33;
                5: opcode = 7'h63;
                default: opcode = 7'($urandom_range(0, 127));
            endcase
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            f7  = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0: imm = 64'($urandom_range(0, 4095));
                1: begin
                    v = $urandom_range(0, 8191) - 4096;
                    imm = 64'(longint'(v));
                end
                2: imm = {$urandom, $urandom};
                default: begin
                    v = $urandom_range(0, 5);
                    case (v)
                        0: imm = 64'd4095;
                        1: imm = 64'd4096;
                        2: imm = 64'd2047;
                        3: imm = 64'd2048;
                        4: imm = 64'hFFFF_FFFF_FFFF_F800;
                        default: imm = 64'hFFFF_FFFF_FFFF_F7FF;
                    endcase
                end
            endcase
            step();
        end
        clr = 1'b0;
        valid = 1'b0;
        wr_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the core's immediate decoder. Accepts decoded instruction fields plus a 64-bit immediate, range-checks the immediate, and scatters it into the 32-bit RISC-V bit layout.
- Buffers encoded words in a 2-entry FIFO and streams them to the instruction-memory write port with a valid/ready handshake and an auto-incrementing address.
- Used by the test loader and self-modifying-program bring-up.

Parameters:
INST_W, 32, instruction word width
DATA_W, 64, immediate input width
ADDR_W, 32, write address width
BASE_ADDR, 0, address of first word after reset/clear

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous reset, active-high
i_clr  input  1  synchronous clear: flush FIFO, address=BASE_ADDR, clear errors
i_valid  input  1  request valid
o_ready  output  1  request accepted when i_valid & o_ready
i_opcode  input  7  opcode[6:0]
i_rd  input  5  destination register
i_rs1  input  5  source 1
i_rs2  input  5  source 2
i_funct3  input  3  funct3
i_funct7  input  7  funct7 (R only)
i_imm  input  DATA_W  immediate value
o_wr_valid  output  1  write request valid
i_wr_ready  input  1  memory accepts write
o_wr_addr  output  ADDR_W  byte address of word
o_wr_data  output  INST_W  encoded instruction
o_err  output  1  sticky error flag
o_err_cnt  output  8  saturating count of dropped requests

Behaviour:
- Reset (i_rst high, async): FIFO empty, o_wr_valid=0, o_wr_addr=BASE_ADDR, o_wr_data=0, o_err=0, o_err_cnt=0. o_ready=0 while i_rst is high.
- o_ready = !full & !i_clr (combinational). When full, no push occurs even if the FIFO pops in the same cycle.
- Latency: a request accepted in cycle N is encoded into a register and appears at the FIFO head no earlier than cycle N+1 (o_wr_valid=1 at N+1 if the FIFO was empty).
- Encoding, other fields from request, opcode in [6:0]:
  - 0010011 / 0000011 (I): [31:20]=imm[11:0], [19:15]=rs1, [14:12]=f3, [11:7]=rd. Legal range is unsigned: imm[63:12]==0.
  - 0100011 (S): [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:7]=imm[4:0]. Range: imm[63:12]==0.
  - 1100011 (B): imm is in halfword units. [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0], plus rs2, rs1, f3. Range is signed: imm[63:11] all equal.
  - 0110011 (R): [31:25]=f7, rs2, rs1, f3, rd. Immediate ignored.
- Error: an unsupported opcode or out-of-range immediate is still accepted (handshake completes) but is not pushed. o_err is set; o_err_cnt increments, saturating at 255.
- Write port:
  - o_wr_valid = FIFO non-empty. o_wr_addr and o_wr_data must hold stable while o_wr_valid & !i_wr_ready.
  - On o_wr_valid & i_wr_ready: pop, and o_wr_addr += 4, wrapping mod 2^ADDR_W.
  - Dropped requests do not consume an address.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- i_clr overrides all handshakes that cycle: FIFO empty, address=BASE_ADDR, o_err=0, o_err_cnt=0. No write is considered accepted in that cycle.
- Reset mid-stream discards all buffered words; the next write goes to BASE_ADDR.

Test Plan:
- I-type: opcode=0010011, rd=1, rs1=2, f3=0, imm=5 -> single write addr=0x0, data=0x00510093, o_wr_valid rises one cycle after accept.
- S then B back-to-back:
  - S: opcode=0100011, f3=2, rs1=2, rs2=3, imm=36 -> addr 0x0, data 0x02312223.
  - B: opcode=1100011, f3=0, rs1=1, rs2=2, imm=-2 (0xFFFF_FFFF_FFFF_FFFE) -> addr 0x4, data 0xFE208EE3.
- Range/opcode errors: I imm=4096, B imm=2048, opcode=1111111 -> no writes, o_err=1, o_err_cnt=3. Following a legal addi, it is written to addr 0x0.
- Backpressure: i_wr_ready=0, 3 legal requests -> first two accepted, o_ready=0 for the third. o_wr_addr/o_wr_data hold stable. Then i_wr_ready=1 -> writes at 0x0, 0x4, 0x8 in order.
- Wrap/clear: ADDR_W=4, 5 writes -> addresses 0,4,8,C,0. Then i_clr with 1 word buffered -> o_wr_valid=0 next cycle, o_err=0, and the next write goes to BASE_ADDR.
- Async reset asserted mid-transfer (FIFO full) -> outputs reach reset values immediately without a clock edge. Traffic after release starts at BASE_ADDR.
